// File: rtl/match_event_counter.sv
// -----------------------------------------------------------------------------
// match_event_counter
//
// Counts single-cycle match pulses from the serial 1011 sequence detector over
// a programmable window of N clock cycles. It then offers the count and a
// saturation flag to a consumer through a valid/ready handshake.
//
// Optional build feature:
//   MATCH_CNT_AUTORESTART_EN - when defined, completing the result handshake
//   starts the next window immediately, using the latched window length.
//   Only abort or reset returns the block to IDLE.
//
// Parameters:
//   CNT_W  width of the match counter and res_count
//   WIN_W  width of win_len and of the internal cycle down-counter
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-low; clears all state
//   start      begin a window (honoured only in IDLE with win_len != 0)
//   abort      synchronous return to IDLE from any state; highest priority
//   win_len    window length N in cycles, sampled when start is accepted
//   z_in       match pulse from the detector, sampled on every rising edge
//   busy       high while counting or reporting
//   res_valid  result available (REPORT state)
//   res_ready  consumer accepts the result
//   res_count  matches counted in the last completed window
//   res_sat    counter saturated during the last completed window
// -----------------------------------------------------------------------------
module match_event_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             z_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [CNT_W-1:0] r_res_count;
  logic             r_res_sat;
`ifdef MATCH_CNT_AUTORESTART_EN
  logic [WIN_W-1:0] r_len;
`endif

  // Control strobes decoded from the current state and inputs.
  logic             w_load;    // accepted start: load window, clear count
  logic             w_sample;  // counting cycle: sample z_in, step remaining
  logic             w_done;    // last counting cycle: publish the result
  logic             w_clear;   // abort: clear count and sat
  logic             w_reload;  // autorestart: reload window after handshake

  logic             w_at_max;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_sat_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode. Abort wins over start, over handshake
  // completion and over window completion in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
    w_reload    = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && (win_len != '0)) begin
            w_load      = 1'b1;
            w_state_nxt = S_COUNT;
          end
        end
        S_COUNT: begin
          w_sample = 1'b1;
          if (r_rem == WIN_W'(1)) begin
            w_done      = 1'b1;
            w_state_nxt = S_REPORT;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
`ifdef MATCH_CNT_AUTORESTART_EN
            w_reload    = 1'b1;
            w_state_nxt = S_COUNT;
`else
            w_state_nxt = S_IDLE;
`endif
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Saturating increment: at all-ones the count holds and sat is raised.
  assign w_at_max    = &r_count;
  assign w_count_nxt = (z_in && !w_at_max) ? r_count + CNT_W'(1) : r_count;
  assign w_sat_nxt   = r_sat | (z_in & w_at_max);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers, not a memory array, so each takes the
  // asynchronous reset and the block leaves reset in a fully known state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem       <= '0;
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_res_count <= '0;
      r_res_sat   <= 1'b0;
`ifdef MATCH_CNT_AUTORESTART_EN
      r_len       <= '0;
`endif
    end else begin
      if (w_clear) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end

      if (w_load) begin
        r_rem   <= win_len;
        r_count <= '0;
        r_sat   <= 1'b0;
`ifdef MATCH_CNT_AUTORESTART_EN
        r_len   <= win_len;
`endif
      end

`ifdef MATCH_CNT_AUTORESTART_EN
      if (w_reload) begin
        r_rem   <= r_len;
        r_count <= '0;
        r_sat   <= 1'b0;
      end
`endif

      if (w_sample) begin
        r_rem   <= r_rem - WIN_W'(1);
        r_count <= w_count_nxt;
        r_sat   <= w_sat_nxt;
        // The final cycle's z_in is folded into the published result.
        if (w_done) begin
          r_res_count <= w_count_nxt;
          r_res_sat   <= w_sat_nxt;
        end
      end
    end
  end

`ifndef MATCH_CNT_AUTORESTART_EN
  // w_reload only has a consumer in the autorestart build.
  logic w_reload_unused;
  assign w_reload_unused = w_reload;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_REPORT);
  assign res_count = r_res_count;
  assign res_sat   = r_res_sat;

endmodule

// File: tb/tb_match_event_counter.sv
// -----------------------------------------------------------------------------
// tb_match_event_counter
//
// Self-checking bench for match_event_counter. Two instances share all
// stimulus: one with CNT_W=8 and one with CNT_W=2, which exercises
// saturation. Each driven window pushes its expected result, computed from
// the z_in pattern, onto a scoreboard queue. A monitor pops the queue and
// compares it with both instances whenever a handshake is seen.
// -----------------------------------------------------------------------------
module tb_match_event_counter;

  localparam int WIN_W = 8;

  typedef struct {
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic             z_in;
  logic             res_ready;

  logic             busy,  res_valid,  res_sat;
  logic [7:0]       res_count;
  logic             busy2, res_valid2, res_sat2;
  logic [1:0]       res_count2;

  int               n_checks = 0;
  int               n_errors = 0;
  int               n_hs     = 0;
  exp_t             sb[$];

  always #5 clk = ~clk;

  match_event_counter #(.CNT_W(8), .WIN_W(WIN_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .z_in(z_in), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_sat(res_sat)
  );

  match_event_counter #(.CNT_W(2), .WIN_W(WIN_W)) u_dut_w2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .z_in(z_in), .busy(busy2), .res_valid(res_valid2),
    .res_ready(res_ready), .res_count(res_count2), .res_sat(res_sat2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected result for a window, from the bench's own saturating model.
  task automatic push_expected(input int len, input logic [63:0] mask);
    exp_t e;
    int   ones = 0;
    for (int i = 0; i < len; i++) ones += int'(mask[i]);
    e.c8 = (ones > 255) ? 8'd255 : 8'(ones);
    e.s8 = (ones > 255);
    e.c2 = (ones > 3) ? 2'd3 : 2'(ones);
    e.s2 = (ones > 3);
    sb.push_back(e);
  endtask

  // Drive one window: start, then z_in = mask[i] sampled on edge k+1+i.
  // Returns at the falling edge after the window-completion edge.
  task automatic run_window(input int len, input logic [63:0] mask,
                            input logic z_on_start, input logic z_after);
    push_expected(len, mask);
    start   = 1'b1;
    win_len = WIN_W'(len);
    z_in    = z_on_start;
    tick();
    start = 1'b0;
    z_in  = mask[0];
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("valid_after_start", res_valid, 0);
    for (int i = 0; i < len; i++) begin
      tick();
      z_in = (i + 1 < len) ? mask[i+1] : z_after;
      @(negedge clk);
      check($sformatf("valid_lat_%0d", i), res_valid, (i == len - 1));
    end
  endtask

  // Let the pending handshake edge pass and confirm the block idles.
  task automatic finish_hs();
    tick();
    z_in = 1'b0;
    @(negedge clk);
    check("valid_after_hs", res_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  // Scoreboard monitor: a handshake will complete on the coming rising edge.
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_count8", res_count, e.c8);
        check("sb_sat8", res_sat, e.s8);
        check("sb_count2", res_count2, e.c2);
        check("sb_sat2", res_sat2, e.s2);
        check("sb_valid2", res_valid2, 1);
      end
      n_hs++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    win_len   = '0;
    z_in      = 1'b0;
    res_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_count", res_count, 0);
    check("rst_sat", res_sat, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef MATCH_CNT_AUTORESTART_EN
    // Continuous windows: each handshake restarts counting.
    res_ready = 1'b1;
    for (int w = 0; w < 3; w++) push_expected(3, 64'h7);
    start   = 1'b1;
    win_len = WIN_W'(3);
    z_in    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      #1;
      if (n_hs >= 3) break;
    end
    check("ar_handshakes", n_hs, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    z_in  = 1'b0;
    @(negedge clk);
    check("ar_abort_busy", busy, 0);
    check("ar_abort_valid", res_valid, 0);
`else
    // Basic count: z_in on counting cycles 2, 5, 9 of a 10-cycle window.
    res_ready = 1'b1;
    run_window(10, 64'h112, 1'b0, 1'b0);
    finish_hs();

    // Back-to-back: start in the cycle right after the handshake edge.
    run_window(5, 64'h15, 1'b0, 1'b0);
    finish_hs();

    // Boundary samples: first and last counting cycles only. A match on the
    // start edge and one sampled in REPORT must not be counted.
    res_ready = 1'b0;
    run_window(4, 64'h9, 1'b1, 1'b1);
    tick();
    z_in      = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bnd_count", res_count, 2);
    finish_hs();

    // Stall: result held stable while res_ready is low; start is ignored.
    res_ready = 1'b0;
    run_window(3, 64'h2, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 1) begin
        start   = 1'b1;
        win_len = WIN_W'(6);
      end
      @(negedge clk);
      check($sformatf("stall_valid_%0d", j), res_valid, 1);
      check($sformatf("stall_count_%0d", j), res_count, 1);
      check($sformatf("stall_sat_%0d", j), res_sat, 0);
    end
    tick();
    start     = 1'b0;
    res_ready = 1'b1;
    finish_hs();

    // Saturation: 8 matches overflow the 2-bit counter only.
    run_window(8, 64'hFF, 1'b0, 1'b0);
    finish_hs();
    check("sat_res_sat2", res_sat2, 1);
    check("sat_res_count2", res_count2, 3);

    // Abort at counting cycle 3 of 10: no result, old result retained.
    start   = 1'b1;
    win_len = WIN_W'(10);
    z_in    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_count_kept", res_count, 8);
    begin
      logic seen_valid = 1'b0;
      for (int j = 0; j < 12; j++) begin
        tick();
        @(negedge clk);
        if (res_valid || busy) seen_valid = 1'b1;
      end
      check("abort_no_valid", seen_valid, 0);
    end
    z_in = 1'b0;

    // Start with win_len = 0 is ignored.
    tick();
    start   = 1'b1;
    win_len = '0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("zero_len_busy", busy, 0);

    // Abort wins over window completion in the same cycle.
    tick();
    start   = 1'b1;
    win_len = WIN_W'(2);
    z_in    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    z_in  = 1'b0;
    @(negedge clk);
    check("abort_vs_done_valid", res_valid, 0);
    check("abort_vs_done_count", res_count, 8);

    // A window after the abort starts from a cleared count.
    tick();
    run_window(3, 64'h1, 1'b0, 1'b0);
    finish_hs();

    // Asynchronous reset mid-window: outputs clear without a clock edge.
    start   = 1'b1;
    win_len = WIN_W'(10);
    z_in    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", res_valid, 0);
    check("async_rst_count", res_count, 0);
    check("async_rst_sat", res_sat, 0);
    tick();
    reset = 1'b1;
    z_in  = 1'b0;
    tick();
`endif

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
